// File: rtl/keypad_emulador_pkg.sv
// Keypad key codes shared with the column-scanning decoder, plus the
// key -> (row, col) position lookup and a valid-key predicate.
package keypad_emulador_pkg;

  typedef enum logic [4:0] {
    T_0    = 5'd0,
    T_1    = 5'd1,
    T_2    = 5'd2,
    T_3    = 5'd3,
    T_4    = 5'd4,
    T_5    = 5'd5,
    T_6    = 5'd6,
    T_7    = 5'd7,
    T_8    = 5'd8,
    T_9    = 5'd9,
    T_A    = 5'd10,
    T_B    = 5'd11,
    T_C    = 5'd12,
    T_D    = 5'd13,
    T_ASTE = 5'd14,
    T_HASH = 5'd15,
    T_NULL = 5'd16
  } teclas_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Only codes 0..15 map to a physical key; T_NULL and 17..31 never close a contact.
  function automatic logic tecla_valida(input logic [4:0] k);
    return (k < 5'd16);
  endfunction

  // Matrix position, rows numbered top to bottom:
  //   col0 = 1 4 7 *   col1 = 2 5 8 0   col2 = 3 6 9 #   col3 = A B C D
  function automatic key_pos_t tecla_pos(input logic [4:0] k);
    key_pos_t p;
    p.row = 2'd0;
    p.col = 2'd0;
    case (k)
      5'd1:  begin p.row = 2'd0; p.col = 2'd0; end
      5'd4:  begin p.row = 2'd1; p.col = 2'd0; end
      5'd7:  begin p.row = 2'd2; p.col = 2'd0; end
      5'd14: begin p.row = 2'd3; p.col = 2'd0; end
      5'd2:  begin p.row = 2'd0; p.col = 2'd1; end
      5'd5:  begin p.row = 2'd1; p.col = 2'd1; end
      5'd8:  begin p.row = 2'd2; p.col = 2'd1; end
      5'd0:  begin p.row = 2'd3; p.col = 2'd1; end
      5'd3:  begin p.row = 2'd0; p.col = 2'd2; end
      5'd6:  begin p.row = 2'd1; p.col = 2'd2; end
      5'd9:  begin p.row = 2'd2; p.col = 2'd2; end
      5'd15: begin p.row = 2'd3; p.col = 2'd2; end
      5'd10: begin p.row = 2'd0; p.col = 2'd3; end
      5'd11: begin p.row = 2'd1; p.col = 2'd3; end
      5'd12: begin p.row = 2'd2; p.col = 2'd3; end
      5'd13: begin p.row = 2'd3; p.col = 2'd3; end
      default: begin p.row = 2'd0; p.col = 2'd0; end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/keypad_emulador_if.sv
// Key handshake plus the row/column matrix lines between a key source,
// the emulated keypad and the scanning decoder.
interface keypad_emulador_if;
  import keypad_emulador_pkg::*;

  logic [4:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] colunas;
  logic [3:0] linhas;
  logic       busy;
  logic       done;

  modport master (
    output key_in, key_valid, colunas,
    input  key_ready, linhas, busy, done
  );

  modport slave (
    input  key_in, key_valid, colunas,
    output key_ready, linhas, busy, done
  );

endinterface

// File: rtl/keypad_emulador.sv
// Emulated 4x4 membrane keypad: accepts one key code at a time and presses it
// for a timed window with contact bounce on press and release.
//
//   state      | meaning
//   IDLE       | waiting for a key, key_ready high
//   BOUNCE_IN  | press bounce, contact toggles every BOUNCE_PERIOD cycles
//   HOLD       | solid contact
//   BOUNCE_OUT | release bounce
//   GAP        | released, waiting before the next key
//
// HOLD_CYCLES and GAP_CYCLES are expected to be >= 1.
module keypad_emulador
  import keypad_emulador_pkg::*;
#(
  parameter int HOLD_CYCLES   = 25000000,
  parameter int BOUNCE_CYCLES = 500000,
  parameter int BOUNCE_PERIOD = 50000,
  parameter int GAP_CYCLES    = 25000000
) (
  input  logic clk,
  input  logic rst,
  keypad_emulador_if.slave kp
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } state_t;

  localparam int MAX_HB = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int MAX_C  = (MAX_HB > GAP_CYCLES) ? MAX_HB : GAP_CYCLES;
  localparam int CW     = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);
  localparam int PW     = (BOUNCE_PERIOD < 2) ? 1 : $clog2(BOUNCE_PERIOD + 1);

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] BOUNCE_LAST = CW'(BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PER_LAST    = PW'(BOUNCE_PERIOD - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [PW-1:0] bcnt;
  logic          bphase;
  logic [4:0]    key_q;
  logic          accept;
  logic          done_n;
  logic          contact;
  logic [3:0]    linhas_n;
  key_pos_t      pos;

  // State register, phase counters, latched key and the done pulse.
  // bcnt/bphase track floor(cnt / BOUNCE_PERIOD) parity without a divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bcnt   <= '0;
      bphase <= 1'b0;
      key_q  <= T_NULL;
      kp.done <= 1'b0;
    end else begin
      state   <= state_n;
      kp.done <= done_n;
      if (accept)
        key_q <= kp.key_in;
      if (state_n != state || state == IDLE) begin
        cnt    <= '0;
        bcnt   <= '0;
        bphase <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        if (bcnt == PER_LAST) begin
          bcnt   <= '0;
          bphase <= ~bphase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  // Next-state decode; each phase ends on its last count.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (kp.key_valid) begin
          accept  = 1'b1;
          state_n = (BOUNCE_CYCLES == 0) ? HOLD : BOUNCE_IN;
        end
      end
      BOUNCE_IN: begin
        if (cnt == BOUNCE_LAST)
          state_n = HOLD;
      end
      HOLD: begin
        if (cnt == HOLD_LAST)
          state_n = (BOUNCE_CYCLES == 0) ? GAP : BOUNCE_OUT;
      end
      BOUNCE_OUT: begin
        if (cnt == BOUNCE_LAST)
          state_n = GAP;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Contact closure for the latched key; non-key codes never close.
  always_comb begin
    contact = 1'b0;
    case (state)
      HOLD:                  contact = 1'b1;
      BOUNCE_IN, BOUNCE_OUT: contact = ~bphase;
      default:               contact = 1'b0;
    endcase
    contact = contact & tecla_valida(key_q);
  end

  // Row drive: only the key's row can go low, and only while its column is scanned.
  always_comb begin
    pos      = tecla_pos(key_q);
    linhas_n = 4'hF;
    for (int r = 0; r < 4; r++)
      linhas_n[r] = ~(contact & ~kp.colunas[pos.col] & (pos.row == 2'(r)));
  end

  // Registered row lines, one cycle behind colunas/contact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      kp.linhas <= 4'hF;
    else
      kp.linhas <= linhas_n;
  end

  assign kp.key_ready = (state == IDLE);
  assign kp.busy      = (state != IDLE);

endmodule

// File: tb/tb_keypad_emulador.sv
// Directed bench for keypad_emulador with HOLD=8, BOUNCE=4, PERIOD=1, GAP=6.
module tb_keypad_emulador;
  import keypad_emulador_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  keypad_emulador_if kpi();

  keypad_emulador #(
    .HOLD_CYCLES  (8),
    .BOUNCE_CYCLES(4),
    .BOUNCE_PERIOD(1),
    .GAP_CYCLES   (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kpi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] k);
    kpi.key_in    = k;
    kpi.key_valid = 1'b1;
    tick();
    kpi.key_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (kpi.done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, {31'd0, seen}, 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       closed;
    logic [3:0] exp_l;
    int         idx;
    int         dones;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    kpi.key_in    = 5'd0;
    kpi.key_valid = 1'b0;
    kpi.colunas   = 4'hF;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_linhas", {28'd0, kpi.linhas}, 32'hF);
    chk("rst_ready",  {31'd0, kpi.key_ready}, 32'd1);
    chk("rst_busy",   {31'd0, kpi.busy}, 32'd0);
    chk("rst_done",   {31'd0, kpi.done}, 32'd0);

    // T_5 during HOLD, column 1 then column 0 scanned
    kpi.colunas = 4'hF;
    send(5'd5);
    chk("t2_busy", {31'd0, kpi.busy}, 32'd1);
    repeat (6) tick();
    kpi.colunas = 4'b1101;
    tick();
    chk("t2_col1", {28'd0, kpi.linhas}, 32'hD);
    kpi.colunas = 4'b1110;
    tick();
    chk("t2_col0", {28'd0, kpi.linhas}, 32'hF);
    wait_done("t2_done");

    // T_D full sequence, column 3 held low
    kpi.colunas = 4'b0111;
    send(5'd13);
    dones = 0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      idx = k - 1;
      if (idx < 4)       closed = (idx % 2 == 0);
      else if (idx < 12) closed = 1'b1;
      else if (idx < 16) closed = ((idx - 12) % 2 == 0);
      else               closed = 1'b0;
      exp_l = closed ? 4'b0111 : 4'hF;
      chk($sformatf("t3_linhas_%0d", k), {28'd0, kpi.linhas}, {28'd0, exp_l});
      chk($sformatf("t3_ready_%0d", k), {31'd0, kpi.key_ready}, (k == 22) ? 32'd1 : 32'd0);
      if (kpi.done) dones++;
    end
    chk("t3_done_last", {31'd0, kpi.done}, 32'd1);
    tick();
    chk("t3_done_clear", {31'd0, kpi.done}, 32'd0);
    chk("t3_done_count", dones, 32'd1);

    // T_NULL never closes; key 2 held valid while busy is taken only at IDLE
    kpi.colunas = 4'b0000;
    send(5'd16);
    kpi.key_in    = 5'd2;
    kpi.key_valid = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      chk($sformatf("t4_linhas_%0d", k), {28'd0, kpi.linhas}, 32'hF);
      chk($sformatf("t4_ready_%0d", k), {31'd0, kpi.key_ready}, 32'd0);
    end
    tick();
    chk("t4_done",  {31'd0, kpi.done}, 32'd1);
    chk("t4_ready", {31'd0, kpi.key_ready}, 32'd1);
    tick();
    chk("t4_accept", {31'd0, kpi.key_ready}, 32'd0);
    kpi.key_valid = 1'b0;
    kpi.colunas   = 4'b1101;
    repeat (5) tick();
    chk("t4_key2_row0", {28'd0, kpi.linhas}, 32'hE);
    wait_done("t4_done2");

    // reset in the middle of HOLD for T_1
    kpi.colunas = 4'b1110;
    send(5'd1);
    repeat (6) tick();
    chk("t5_hold", {28'd0, kpi.linhas}, 32'hE);
    rst = 1'b1;
    #1;
    chk("t5_rst_linhas", {28'd0, kpi.linhas}, 32'hF);
    chk("t5_rst_ready",  {31'd0, kpi.key_ready}, 32'd1);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (kpi.done) dones++;
    end
    chk("t5_no_done", dones, 32'd0);
    chk("t5_ready",   {31'd0, kpi.key_ready}, 32'd1);
    chk("t5_linhas",  {28'd0, kpi.linhas}, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
